// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: preloads a scan chain, optionally captures a registered adder result,
// unloads the chain and compares it against the expected word.
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN = 5
) (
    input  logic                 CK,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [3:0]           pat_a,
    input  logic [3:0]           pat_b,
    input  logic [CHAIN_LEN-1:0] load,
    input  logic                 scan_out,
    output logic [3:0]           a,
    output logic [3:0]           b,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [7:0]           fail_cnt
);

    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LastCnt = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StCapture,
        StShiftOut,
        StDone
    } state_e;

    state_e               r_state;
    logic                 r_mode;
    logic [CHAIN_LEN-1:0] r_load;
    logic [CHAIN_LEN-1:0] r_shift;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_a;
    logic [3:0]           r_b;
    logic                 r_scan_en;
    logic                 r_scan_in;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [CHAIN_LEN-1:0] r_captured;
    logic [7:0]           r_fail_cnt;

    logic [4:0]           w_sum;
    logic [CHAIN_LEN-1:0] w_expected;
    logic [CHAIN_LEN-1:0] w_cap_next;

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_expected = r_mode ? r_load : CHAIN_LEN'(w_sum);
    // Last chain flop arrives first, so it ends up in the MSB after CHAIN_LEN shifts
    assign w_cap_next = (r_captured << 1) | CHAIN_LEN'(scan_out);

    always_ff @(posedge CK) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_mode     <= 1'b0;
            r_load     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_scan_en  <= 1'b0;
            r_scan_in  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_captured <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_load     <= load;
                        r_shift    <= load << 1;
                        r_a        <= pat_a;
                        r_b        <= pat_b;
                        r_cnt      <= '0;
                        r_captured <= '0;
                        r_scan_en  <= 1'b1;
                        r_scan_in  <= load[CHAIN_LEN-1];
                        r_busy     <= 1'b1;
                        r_state    <= StShiftIn;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StShiftIn: begin
                    if (r_cnt == LastCnt) begin
                        r_cnt     <= '0;
                        r_scan_in <= 1'b0;
                        if (r_mode) begin
                            r_scan_en <= 1'b1;
                            r_state   <= StShiftOut;
                        end else begin
                            r_scan_en <= 1'b0;
                            r_state   <= StCapture;
                        end
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_scan_in <= r_shift[CHAIN_LEN-1];
                        r_shift   <= r_shift << 1;
                    end
                end
                StCapture: begin
                    r_scan_en <= 1'b1;
                    r_scan_in <= 1'b0;
                    r_state   <= StShiftOut;
                end
                StShiftOut: begin
                    r_captured <= w_cap_next;
                    if (r_cnt == LastCnt) begin
                        r_cnt     <= '0;
                        r_scan_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= (w_cap_next == w_expected);
                        if ((w_cap_next != w_expected) && (r_fail_cnt != 8'hFF)) begin
                            r_fail_cnt <= r_fail_cnt + 8'd1;
                        end
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign scan_enable = r_scan_en;
    assign scan_in     = r_scan_in;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign captured    = r_captured;
    assign fail_cnt    = r_fail_cnt;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: models the attached 5-flop chain and registered adder,
// queues expected results per test and checks them whenever done pulses.
module tb_scan_test_ctrl;

    logic       CK = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [3:0] pat_a;
    logic [3:0] pat_b;
    logic [4:0] load;
    logic       scan_out;
    logic [3:0] a;
    logic [3:0] b;
    logic       scan_enable;
    logic       scan_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] captured;
    logic [7:0] fail_cnt;

    logic [4:0] chain;
    logic       force0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic [4:0] cap;
        logic       pass;
        logic [7:0] fcnt;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb_q[$];

    scan_test_ctrl #(.CHAIN_LEN(5)) dut (
        .CK          (CK),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .pat_a       (pat_a),
        .pat_b       (pat_b),
        .load        (load),
        .scan_out    (scan_out),
        .a           (a),
        .b           (b),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .captured    (captured),
        .fail_cnt    (fail_cnt)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    // Scan chain around the adder result register: shifts when enabled, else captures a+b
    always @(posedge CK) begin
        if (scan_enable) chain <= {chain[3:0], scan_in};
        else             chain <= {1'b0, a} + {1'b0, b};
    end

    assign scan_out = force0 ? 1'b0 : chain[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CK) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending test (t=%0t)",
                         $time);
            end else begin
                e = sb_q.pop_front();
                check("captured", 32'(captured), 32'(e.cap));
                check("pass", 32'(pass), 32'(e.pass));
                check("fail_cnt", 32'(fail_cnt), 32'(e.fcnt));
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // Starts one test from the current negedge; returns after the post-DONE cycle, or at the
    // DONE negedge when b2b is set so the caller can chain the next test.
    task automatic issue(input bit m, input logic [3:0] pa, input logic [3:0] pb,
                         input logic [4:0] ld, input logic [4:0] ecap, input bit epass,
                         input logic [7:0] efc, input bit pulse, input bit b2b);
        exp_t e;
        int   run;
        bit   seen;
        mode  = m;
        pat_a = pa;
        pat_b = pb;
        load  = ld;
        start = 1'b1;
        e.cap  = ecap;
        e.pass = epass;
        e.fcnt = efc;
        e.lat  = m ? 11 : 12;
        e.t0   = cyc;
        sb_q.push_back(e);
        @(negedge CK);
        start = 1'b0;
        pat_a = ~pa;
        pat_b = ~pb;
        load  = ~ld;
        mode  = ~m;
        check("a_latched", 32'(a), 32'(pa));
        check("b_latched", 32'(b), 32'(pb));
        check("captured_cleared", 32'(captured), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        run = 0;
        while (scan_enable === 1'b1 && run < 20) begin
            if (run < 5) check("scan_in", 32'(scan_in), 32'(ld[4-run]));
            run++;
            @(negedge CK);
        end
        check("se_run_len", 32'(run), m ? 32'd10 : 32'd5);
        if (pulse) begin
            @(negedge CK);
            start = 1'b1;
            mode  = 1'b1;
            load  = 5'h1B;
            @(negedge CK);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge CK);
        end
        check("done_seen", 32'(seen), 32'd1);
        if (!b2b) begin
            @(negedge CK);
            check("idle_busy", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
            check("pass_held", 32'(pass), 32'(epass));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
        pat_a  = '0;
        pat_b  = '0;
        load   = '0;
        force0 = 1'b0;
        repeat (2) @(negedge CK);
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_scan_enable", 32'(scan_enable), 32'd0);
        check("rst_scan_in", 32'(scan_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_captured", 32'(captured), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge CK);

        // F+1 = 0x10 captured; a start pulse during SHIFT_OUT must be ignored
        issue(1'b0, 4'hF, 4'h1, 5'h0A, 5'h10, 1'b1, 8'd0, 1'b1, 1'b0);
        // Chain-integrity test chained straight into a functional test (2+5 = 7)
        issue(1'b1, 4'h6, 4'h9, 5'h15, 5'h15, 1'b1, 8'd0, 1'b0, 1'b1);
        issue(1'b0, 4'h2, 4'h5, 5'h1F, 5'h07, 1'b1, 8'd0, 1'b0, 1'b0);

        // Broken chain: every functional test fails, counter saturates
        force0 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            issue(1'b0, 4'h3, 4'h4, 5'h05, 5'h00, 1'b0, (i > 255) ? 8'hFF : 8'(i),
                  1'b0, 1'b0);
        end
        check("fail_cnt_saturated", 32'(fail_cnt), 32'hFF);
        force0 = 1'b0;

        // Reset in the 3rd SHIFT_OUT cycle (cycle 9), with start held during reset
        mode  = 1'b0;
        pat_a = 4'h1;
        pat_b = 4'h1;
        load  = 5'h00;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (8) @(negedge CK);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge CK);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_captured", 32'(captured), 32'd0);
        check("abort_scan_enable", 32'(scan_enable), 32'd0);
        check("abort_fail_cnt", 32'(fail_cnt), 32'd0);
        check("abort_a", 32'(a), 32'd0);
        @(negedge CK);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge CK);
        check("start_ignored_in_reset", 32'(busy), 32'd0);
        repeat (20) @(negedge CK);

        issue(1'b1, 4'h7, 4'h8, 5'h0A, 5'h0A, 1'b1, 8'd0, 1'b0, 1'b0);

        repeat (5) @(negedge CK);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/scan_test_ctrl.md
SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 5, meaning the number of scan flops in the attached chain, MSB first at scan_out.
REQ-002 SHALL have port CK  input  1  single clock, all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  test request, sampled only in IDLE or DONE.
REQ-005 SHALL have port mode  input  1  0 = functional test (shift-in, capture, shift-out), 1 = chain-integrity test (shift-in, shift-out).
REQ-006 SHALL have port pat_a  input  4  adder operand A pattern.
REQ-007 SHALL have port pat_b  input  4  adder operand B pattern.
REQ-008 SHALL have port load  input  CHAIN_LEN  word to preload into the chain.
REQ-009 SHALL have port scan_out  input  1  serial return from the last chain flop.
REQ-010 SHALL have port a  output  4  operand A to the registered adder.
REQ-011 SHALL have port b  output  4  operand B to the registered adder.
REQ-012 SHALL have port scan_enable  output  1  chain shift enable.
REQ-013 SHALL have port scan_in  output  1  serial data into the first chain flop.
REQ-014 SHALL have port busy  output  1  test in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port pass  output  1  result of the last completed test.
REQ-017 SHALL have port captured  output  CHAIN_LEN  word unloaded from the chain.
REQ-018 SHALL have port fail_cnt  output  8  count of failed tests, saturating.

Function
REQ-019 SHALL implement states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT and DONE.
REQ-020 SHALL, when start=1 in IDLE or DONE, latch pat_a, pat_b, load and mode, and go to SHIFT_IN.
REQ-021 SHALL ignore start in SHIFT_IN, CAPTURE and SHIFT_OUT; latched values SHALL stay unchanged.
REQ-022 SHALL drive a and b from the latched patterns from the cycle after acceptance until the next accepted start.
REQ-023 SHALL stay in SHIFT_IN for exactly CHAIN_LEN cycles.
REQ-024 SHALL, in SHIFT_IN, drive scan_enable=1 and drive scan_in=load[CHAIN_LEN-1-j] in cycle j (j=0..CHAIN_LEN-1), MSB first.
REQ-025 SHALL, after SHIFT_IN, go to CAPTURE when mode=0 and directly to SHIFT_OUT when mode=1.
REQ-026 SHALL stay in CAPTURE for exactly 1 cycle with scan_enable=0, so that the adder registers a+b on that edge.
REQ-027 SHALL stay in SHIFT_OUT for exactly CHAIN_LEN cycles with scan_enable=1 and scan_in=0.
REQ-028 SHALL, at the end of each SHIFT_OUT cycle, update captured to {captured[CHAIN_LEN-2:0], scan_out}; after CHAIN_LEN cycles, captured[i] SHALL equal chain flop i.
REQ-029 SHALL clear captured to 0 on entry to SHIFT_IN.
REQ-030 SHALL compute the expected word as zero-extended a+b (5 bits, carry in bit 4) when mode=0, and as load when mode=1.
REQ-031 SHALL, in DONE, hold done=1 for exactly 1 cycle, set pass = (captured == expected) and keep pass until the next DONE.
REQ-032 SHALL, in DONE with pass=0, increment fail_cnt by 1, saturating at 8'hFF.
REQ-033 SHALL, in DONE, go to SHIFT_IN if start=1 (back-to-back test), otherwise to IDLE.
REQ-034 SHALL hold busy=1 exactly in SHIFT_IN, CAPTURE and SHIFT_OUT.
REQ-035 SHALL drive scan_enable, scan_in, a and b from flops, with no combinational path from any input.
REQ-036 SHALL give a latency, counted from the start-sampling edge, of done high in cycle 2*CHAIN_LEN+2 for mode=0 (cycle 12 at default) and cycle 2*CHAIN_LEN+1 for mode=1 (cycle 11 at default).

Reset
REQ-037 SHALL, with rst_n=0 at a rising edge, set state=IDLE and all outputs to 0 (a, b, scan_enable, scan_in, busy, done, pass, captured, fail_cnt).
REQ-038 SHALL, if reset occurs in any state, abort the test with no done pulse and leave no partial captured value.
REQ-039 SHALL ignore start while rst_n=0.

Verification
REQ-040 SHALL be verified by: rst_n=0 for 2 cycles -> all outputs 0, state IDLE.
REQ-041 SHALL be verified by: mode=0, pat_a=4'hF, pat_b=4'h1, load=5'h0A -> scan_in carries 0,1,0,1,0; done in cycle 12; captured=5'h10; pass=1; fail_cnt=0.
REQ-042 SHALL be verified by: mode=1, load=5'h15 -> scan_enable high for 10 consecutive cycles; done in cycle 11; captured=5'h15; pass=1.
REQ-043 SHALL be verified by: scan_out forced to 0, mode=0, pat_a=3, pat_b=4 -> captured=5'h00; pass=0; fail_cnt=1; repeated 256 times -> fail_cnt stays at 8'hFF.
REQ-044 SHALL be verified by: start pulsed in SHIFT_OUT -> ignored; start held in the DONE cycle -> next test begins with no IDLE cycle.
REQ-045 SHALL be verified by: rst_n=0 in the 3rd SHIFT_OUT cycle -> next cycle IDLE, busy=0, done never asserted, captured=0.
